// File: rtl/burst_pattern_gen.sv
// burst_pattern_gen: writes bursts of generated test-pattern words into a
// downstream FIFO with a programmable inter-burst gap and FIFO back-pressure.
module burst_pattern_gen #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BURST_LEN = 1024,
    parameter int unsigned GAP_LEN   = 64,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              burst_done,
    output logic [15:0]       burst_count
);

    localparam int unsigned BEAT_W = $clog2(BURST_LEN + 1);
    localparam int unsigned GAP_W  = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;

    localparam logic [1:0] MODE_CNT  = 2'd0;
    localparam logic [1:0] MODE_LFSR = 2'd1;
    localparam logic [1:0] MODE_WALK = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_GAP   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [15:0]         lfsr_nxt;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [15:0]         count_q, count_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                start_burst;

    // First word of a burst for the selected pattern
    function automatic logic [DATA_W-1:0] pat_start(input logic [1:0] m, input logic [15:0] lfsr);
        case (m)
            MODE_CNT:  pat_start = '0;
            MODE_LFSR: pat_start = lfsr[DATA_W-1:0];
            MODE_WALK: pat_start = DATA_W'(1);
            default:   pat_start = DATA_W'(16'h5555);
        endcase
    endfunction

    // Word following d in the selected pattern; LFSR words come from the advanced register
    function automatic logic [DATA_W-1:0] pat_next(input logic [1:0] m, input logic [DATA_W-1:0] d,
                                                   input logic [15:0] lfsr_adv);
        case (m)
            MODE_CNT:  pat_next = d + DATA_W'(1);
            MODE_LFSR: pat_next = lfsr_adv[DATA_W-1:0];
            MODE_WALK: pat_next = {d[DATA_W-2:0], d[DATA_W-1]};
            default:   pat_next = ~d;
        endcase
    endfunction

    // Write strobe is the one combinational output so back-pressure takes effect the same cycle
    assign fifo_wr_en = (state_q == S_BURST) && !fifo_full;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0
    assign lfsr_nxt = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // Next-state, pattern and counter logic
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        data_d      = data_q;
        lfsr_d      = lfsr_q;
        beat_d      = beat_q;
        gap_d       = gap_q;
        count_d     = count_q;
        done_d      = 1'b0;
        start_burst = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en) start_burst = 1'b1;
            end
            S_BURST: begin
                if (fifo_wr_en) begin
                    if (mode_q == MODE_LFSR) lfsr_d = lfsr_nxt;
                    data_d = pat_next(mode_q, data_q, lfsr_nxt);
                    if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
                        count_d = count_q + 16'd1;
                        done_d  = 1'b1;
                        beat_d  = '0;
                        if (GAP_LEN > 0) begin
                            state_d = S_GAP;
                            gap_d   = '0;
                        end else if (en) begin
                            start_burst = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GAP_W'(GAP_LEN - 1)) begin
                    if (en) start_burst = 1'b1;
                    else    state_d     = S_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Burst start: latch mode and load the pattern start (LFSR continues from its current value)
        if (start_burst) begin
            state_d = S_BURST;
            mode_d  = mode;
            beat_d  = '0;
            data_d  = pat_start(mode, lfsr_d);
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= '0;
            data_q  <= '0;
            lfsr_q  <= LFSR_SEED;
            beat_q  <= '0;
            gap_q   <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            lfsr_q  <= lfsr_d;
            beat_q  <= beat_d;
            gap_q   <= gap_d;
            count_q <= count_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign data        = data_q;
    assign busy        = busy_q;
    assign burst_done  = done_q;
    assign burst_count = count_q;

endmodule

// File: tb/tb_burst_pattern_gen.sv
// Directed testbench for burst_pattern_gen: a short-burst instance (4 beats, gap 2)
// and a long-burst zero-gap instance (300 beats) for counter wrap.
module tb_burst_pattern_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        fifo_full = 1'b0;
    logic        wr;
    logic [7:0]  data;
    logic        busy;
    logic        done;
    logic [15:0] bcount;

    logic        rst_b_n = 1'b0;
    logic        en_b = 1'b0;
    logic [1:0]  mode_b = 2'd0;
    logic        full_b = 1'b0;
    logic        wr_b;
    logic [7:0]  data_b;
    logic        busy_b;
    logic        done_b;
    logic [15:0] bcount_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    burst_pattern_gen #(.DATA_W(8), .BURST_LEN(4), .GAP_LEN(2), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .fifo_full(fifo_full),
        .fifo_wr_en(wr), .data(data), .busy(busy), .burst_done(done), .burst_count(bcount)
    );

    burst_pattern_gen #(.DATA_W(8), .BURST_LEN(300), .GAP_LEN(0), .LFSR_SEED(16'hACE1)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .en(en_b), .mode(mode_b), .fifo_full(full_b),
        .fifo_wr_en(wr_b), .data(data_b), .busy(busy_b), .burst_done(done_b), .burst_count(bcount_b)
    );

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        lfsr_step = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (wr !== 1'b0) begin failures++; $display("FAIL reset_wr got %b exp 0", wr); end
        checks++; if (data !== 8'h00) begin failures++; $display("FAIL reset_data got %h exp 00", data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (bcount !== 16'd0) begin failures++; $display("FAIL reset_count got %0d exp 0", bcount); end
        checks++; if (wr_b !== 1'b0) begin failures++; $display("FAIL reset_b_wr got %b exp 0", wr_b); end
        @(negedge clk);
        rst_n = 1'b1;
        rst_b_n = 1'b1;
    endtask

    // Two counter bursts back to back, en dropped during the second
    task automatic test_counter();
        logic ew, ed, eb;
        logic [7:0] exd;
        for (int t = 0; t < 14; t++) begin
            @(negedge clk);
            en = (t < 8); mode = 2'd0; fifo_full = 1'b0;
            #1;
            ew  = (t >= 1 && t <= 4) || (t >= 7 && t <= 10);
            ed  = (t == 5) || (t == 11);
            eb  = (t >= 1 && t <= 12);
            exd = (t <= 4) ? 8'(t - 1) : 8'(t - 7);
            checks++; if (wr !== ew) begin failures++; $display("FAIL counter_wr t=%0d got %b exp %b", t, wr, ew); end
            checks++; if (done !== ed) begin failures++; $display("FAIL counter_done t=%0d got %b exp %b", t, done, ed); end
            checks++; if (busy !== eb) begin failures++; $display("FAIL counter_busy t=%0d got %b exp %b", t, busy, eb); end
            if (ew) begin
                checks++; if (data !== exd) begin failures++; $display("FAIL counter_data t=%0d got %h exp %h", t, data, exd); end
            end
            if (t == 5 || t == 11) begin
                checks++;
                if (bcount !== ((t == 5) ? 16'd1 : 16'd2)) begin
                    failures++; $display("FAIL counter_count t=%0d got %0d exp %0d", t, bcount, (t == 5) ? 1 : 2);
                end
            end
        end
    endtask

    // fifo_full for 5 cycles after the first word: data held, no skip or repeat
    task automatic test_stall();
        logic ew, eb;
        logic [7:0] exd;
        for (int t = 0; t < 13; t++) begin
            @(negedge clk);
            en = (t < 2); mode = 2'd0; fifo_full = (t >= 2 && t <= 6);
            #1;
            ew  = (t == 1) || (t >= 7 && t <= 9);
            eb  = (t >= 1 && t <= 11);
            exd = (t == 1) ? 8'h00 : (t <= 7) ? 8'h01 : 8'(t - 6);
            checks++; if (wr !== ew) begin failures++; $display("FAIL stall_wr t=%0d got %b exp %b", t, wr, ew); end
            checks++; if (busy !== eb) begin failures++; $display("FAIL stall_busy t=%0d got %b exp %b", t, busy, eb); end
            if (t >= 1 && t <= 9) begin
                checks++; if (data !== exd) begin failures++; $display("FAIL stall_data t=%0d got %h exp %h", t, data, exd); end
            end
            if (t == 10) begin
                checks++; if (done !== 1'b1) begin failures++; $display("FAIL stall_done got %b exp 1", done); end
                checks++; if (bcount !== 16'd3) begin failures++; $display("FAIL stall_count got %0d exp 3", bcount); end
            end
        end
    endtask

    // fifo_full on the last beat: that beat retried, burst_done delayed accordingly
    task automatic test_last_stall();
        logic ew, ed;
        logic [7:0] exd;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            en = (t < 2); mode = 2'd0; fifo_full = (t == 4 || t == 5);
            #1;
            ew  = (t >= 1 && t <= 3) || (t == 6);
            ed  = (t == 7);
            exd = (t <= 3) ? 8'(t - 1) : 8'h03;
            checks++; if (wr !== ew) begin failures++; $display("FAIL last_stall_wr t=%0d got %b exp %b", t, wr, ew); end
            checks++; if (done !== ed) begin failures++; $display("FAIL last_stall_done t=%0d got %b exp %b", t, done, ed); end
            if (t >= 1 && t <= 6) begin
                checks++; if (data !== exd) begin failures++; $display("FAIL last_stall_data t=%0d got %h exp %h", t, data, exd); end
            end
            if (t == 7) begin
                checks++; if (bcount !== 16'd4) begin failures++; $display("FAIL last_stall_count got %0d exp 4", bcount); end
            end
        end
    endtask

    // Three LFSR bursts; sequence continues across bursts; mid-burst mode change ignored
    task automatic test_lfsr();
        logic [15:0] ref_lfsr = 16'hACE1;
        logic ew, ed;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            en = (t < 13); mode = (t == 2 || t == 3) ? 2'd3 : 2'd1; fifo_full = 1'b0;
            #1;
            ew = (t >= 1 && t <= 4) || (t >= 7 && t <= 10) || (t >= 13 && t <= 16);
            ed = (t == 5) || (t == 11) || (t == 17);
            checks++; if (wr !== ew) begin failures++; $display("FAIL lfsr_wr t=%0d got %b exp %b", t, wr, ew); end
            checks++; if (done !== ed) begin failures++; $display("FAIL lfsr_done t=%0d got %b exp %b", t, done, ed); end
            if (ew) begin
                checks++;
                if (data !== ref_lfsr[7:0]) begin
                    failures++; $display("FAIL lfsr_data t=%0d got %h exp %h", t, data, ref_lfsr[7:0]);
                end
                ref_lfsr = lfsr_step(ref_lfsr);
            end
            if (t == 19) begin
                checks++; if (busy !== 1'b0) begin failures++; $display("FAIL lfsr_busy got %b exp 0", busy); end
                checks++; if (bcount !== 16'd7) begin failures++; $display("FAIL lfsr_count got %0d exp 7", bcount); end
            end
        end
    endtask

    // en dropped on beat 1: walking-one burst completes, gap runs, then idle
    task automatic test_en_drop();
        logic ew, eb;
        logic [7:0] exd;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            en = (t < 2); mode = 2'd2; fifo_full = 1'b0;
            #1;
            ew  = (t >= 1 && t <= 4);
            eb  = (t >= 1 && t <= 6);
            exd = 8'h01 << (t - 1);
            checks++; if (wr !== ew) begin failures++; $display("FAIL en_drop_wr t=%0d got %b exp %b", t, wr, ew); end
            checks++; if (busy !== eb) begin failures++; $display("FAIL en_drop_busy t=%0d got %b exp %b", t, busy, eb); end
            if (ew) begin
                checks++; if (data !== exd) begin failures++; $display("FAIL en_drop_data t=%0d got %h exp %h", t, data, exd); end
            end
            if (t == 5) begin
                checks++; if (done !== 1'b1) begin failures++; $display("FAIL en_drop_done got %b exp 1", done); end
                checks++; if (bcount !== 16'd8) begin failures++; $display("FAIL en_drop_count got %0d exp 8", bcount); end
            end
        end
    endtask

    // Reset on beat 2 aborts at once; afterwards the LFSR is back at its seed
    task automatic test_reset_mid();
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            en = 1'b1; mode = 2'd0; fifo_full = 1'b0;
            #1;
            if (t >= 1) begin
                checks++; if (data !== 8'(t - 1)) begin failures++; $display("FAIL rst_mid_pre_data t=%0d got %h exp %h", t, data, 8'(t - 1)); end
            end
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (wr !== 1'b0) begin failures++; $display("FAIL rst_mid_wr got %b exp 0", wr); end
        checks++; if (data !== 8'h00) begin failures++; $display("FAIL rst_mid_data got %h exp 00", data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_mid_done got %b exp 0", done); end
        checks++; if (bcount !== 16'd0) begin failures++; $display("FAIL rst_mid_count got %0d exp 0", bcount); end
        @(negedge clk);
        en = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        en = 1'b1; mode = 2'd1;
        @(negedge clk);
        en = 1'b0;
        #1;
        checks++; if (wr !== 1'b1) begin failures++; $display("FAIL rst_mid_lfsr_wr got %b exp 1", wr); end
        checks++; if (data !== 8'hE1) begin failures++; $display("FAIL rst_mid_lfsr_data got %h exp e1", data); end
        repeat (8) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_end_busy got %b exp 0", busy); end
    endtask

    // 300-beat counter burst wraps FF->00; zero gap restarts immediately while en held
    task automatic test_wrap_back_to_back();
        logic [7:0] exd;
        for (int t = 0; t < 302; t++) begin
            @(negedge clk);
            en_b = (t <= 300); mode_b = 2'd0; full_b = 1'b0;
            #1;
            exd = (t == 301) ? 8'h00 : 8'(t - 1);
            checks++;
            if (wr_b !== (t >= 1)) begin failures++; $display("FAIL wrap_wr t=%0d got %b exp %b", t, wr_b, t >= 1); end
            if (t >= 1) begin
                checks++; if (data_b !== exd) begin failures++; $display("FAIL wrap_data t=%0d got %h exp %h", t, data_b, exd); end
            end
            if (t == 300) begin
                checks++; if (done_b !== 1'b0) begin failures++; $display("FAIL wrap_done_early got %b exp 0", done_b); end
            end
            if (t == 301) begin
                checks++; if (done_b !== 1'b1) begin failures++; $display("FAIL wrap_done got %b exp 1", done_b); end
                checks++; if (busy_b !== 1'b1) begin failures++; $display("FAIL wrap_busy got %b exp 1", busy_b); end
                checks++; if (bcount_b !== 16'd1) begin failures++; $display("FAIL wrap_count got %0d exp 1", bcount_b); end
            end
        end
        @(negedge clk);
        en_b = 1'b0;
        rst_b_n = 1'b0;
    endtask

    initial begin
        test_reset();
        test_counter();
        test_stall();
        test_last_stall();
        test_lfsr();
        test_en_drop();
        test_reset_mid();
        test_wrap_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/burst_pattern_gen.md
# burst_pattern_gen

Parametrised test-pattern source that writes bursts of generated data words into a downstream FIFO, with programmable burst length, inter-burst gap, and selectable data pattern. It honours FIFO back-pressure and can be enabled and disabled at run time. It sits in front of the capture/transfer FIFO in PC-link bring-up and loopback test builds.

## Interface
- DATA_W, 8: data word width; legal range 4..16.
- BURST_LEN, 1024: words written per burst; ≥1.
- GAP_LEN, 64: idle cycles between bursts; 0 allowed.
- LFSR_SEED, 16'hACE1: LFSR reset/reload value; must be nonzero.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  run enable, level-sensitive.
- mode  in  2  pattern select, latched at burst start: 0 counter, 1 LFSR, 2 walking-one, 3 alternating.
- fifo_full  in  1  downstream FIFO full; blocks writes.
- fifo_wr_en  out  1  write strobe to FIFO.
- data  out  DATA_W  write data, valid whenever fifo_wr_en=1.
- busy  out  1  high in BURST or GAP.
- burst_done  out  1  one-cycle pulse after the last word of a burst is written.
- burst_count  out  16  completed-burst count, wraps 0xFFFF→0.

## Operation
- FSM states: IDLE, BURST, GAP.
- IDLE: fifo_wr_en=0, busy=0. When en=1, latch mode, load the pattern start value, clear beat counter, and go to BURST.
- BURST: fifo_wr_en = (state==BURST) && !fifo_full, the only combinational output. Each cycle with fifo_wr_en=1 is one accepted write; the beat counter increments and data advances to the next pattern value. fifo_full=1 holds data and counter unchanged.
- On the write with beat counter = BURST_LEN-1: burst_count+1, burst_done pulses next cycle. Next state is GAP if GAP_LEN>0. Otherwise the FSM re-evaluates en as in IDLE and goes straight to BURST or IDLE.
- GAP: fifo_wr_en=0. Runs exactly GAP_LEN cycles, then goes to BURST (relatching mode and reloading start value) if en=1, else IDLE.
- en deassert mid-burst: the burst completes in full, then the gap runs, then the FSM goes to IDLE. Bursts are never truncated.
- mode changes mid-burst are ignored until the next burst start.
- Patterns, start value then per-write update:
  - counter: 0, then +1 mod 2^DATA_W; wraps when BURST_LEN > 2^DATA_W.
  - LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1, shifting left with feedback into bit0; data = low DATA_W bits. Continues across bursts. Reloads LFSR_SEED only on reset.
  - walking-one: 1, then rotate left by 1 within DATA_W.
  - alternating: 0x55..55 truncated to DATA_W, then bitwise inverted each write.
- Beat counter width: clog2(BURST_LEN+1). Gap counter width: clog2(GAP_LEN+1).

## Timing
- Reset (async assert, sync release): state=IDLE, fifo_wr_en=0, data=0, busy=0, burst_done=0, burst_count=0, LFSR=LFSR_SEED, counters 0.
- Reset mid-burst aborts immediately. No partial burst_done and no count increment.
- en high at edge N (state IDLE) → state=BURST and first fifo_wr_en (if !fifo_full) in cycle N+1.
- Unstalled burst: BURST_LEN consecutive fifo_wr_en cycles, then burst_done=1 for one cycle, coincident with the first GAP cycle.
- Burst period with no stall and en held: BURST_LEN+GAP_LEN cycles.
- fifo_full asserted in the same cycle as the last beat: that beat is not written. It is retried once full clears.

## Test plan
- Reset, en=1, mode=0, DATA_W=8, BURST_LEN=4, GAP_LEN=2, fifo_full=0 → writes 00,01,02,03; burst_done at cycle 5; 2 idle cycles; repeat with burst_count=1→2.
- mode=0, BURST_LEN=300 → data wraps FF→00 at beat 256; exactly 300 writes.
- fifo_full high on beats 1–3 of 0..3 burst for 5 cycles → no writes while full; sequence 00,01,02,03 with no skipped or duplicated values.
- mode=1, seed ACE1, 3 bursts of 4 → 12 writes matching reference LFSR low bytes; sequence continuous across bursts.
- en dropped on beat 1 of 4, GAP_LEN=2 → 4 writes complete, 2 gap cycles, IDLE with busy=0; mode=2 data 01,02,04,08.
- rst_n low mid-burst on beat 2 → fifo_wr_en=0 immediately; all outputs at reset values; burst_count=0.
